serial_adder_sub: RTL and testbench

Parametrised bit-serial adder/subtractor for the CPU datapath; successor to the 1-bit full adder cell (ports A, B, CIN, S, COUT).
- Reuses one full-adder slice over WIDTH clock cycles, LSB first, with a latched carry between cycles.
- Adds a subtract mode, a start/done handshake, and signed-overflow and zero flags.
- Results are registered and held until the next operation completes.

---
 rtl/serial_adder_sub.sv | 140 ++++++++++++++
 tb/tb_serial_adder_sub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sub.sv
// -----------------------------------------------------------------------------
// serial_adder_sub
//   Bit-serial adder/subtractor. One full-adder slice is reused over WIDTH
//   clock cycles, LSB first, with the carry held in a register between cycles.
//   Subtraction is A + ~B + ~CIN, so CIN acts as a borrow-in and COUT=1 means
//   "no borrow". Results are registered and held until the next operation
//   completes.
//
// Ports
//   CLK    in   clock, rising edge
//   RST_N  in   synchronous active-low reset
//   START  in   operation request (sampled in IDLE or DONE only)
//   OP     in   0 = add, 1 = subtract
//   A, B   in   WIDTH-bit operands, sampled with START
//   CIN    in   carry-in (add) / borrow-in (subtract), sampled with START
//   BUSY   out  high while bits are being processed
//   DONE   out  one-cycle pulse when S/COUT/OVF/ZERO were updated
//   S      out  registered result (modulo 2^WIDTH)
//   COUT   out  final carry-out
//   OVF    out  signed overflow (carry into MSB xor carry out of MSB)
//   ZERO   out  high when S == 0
// -----------------------------------------------------------------------------
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             last_bit;
  logic             load;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder slice and result shift
  always_comb begin
    sum_bit   = sa[0] ^ sb[0] ^ c;
    carry_nxt = maj3(sa[0], sb[0], c);
    res_nxt   = {sum_bit, res[WIDTH-1:1]};
    last_bit  = (state == ST_RUN) && (cnt == LAST);
    load      = START && ((state == ST_IDLE) || (state == ST_DONE));
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = ST_IDLE;
    unique case (state)
      ST_IDLE: state_nxt = START ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt = (cnt == LAST) ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = START ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    unique case (state)
      ST_RUN:  BUSY = 1'b1;
      ST_DONE: DONE = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand load, serial processing, result commit
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      S    <= '0;
      COUT <= 1'b0;
      OVF  <= 1'b0;
      ZERO <= 1'b1;
    end else if (load) begin
      sa  <= A;
      sb  <= OP ? ~B : B;
      c   <= OP ? ~CIN : CIN;
      res <= '0;
      cnt <= '0;
    end else if (state == ST_RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= res_nxt;
      c   <= carry_nxt;
      cnt <= cnt + CW'(1);
      if (last_bit) begin
        // While processing the MSB, c still holds the carry into it, so the
        // overflow flag can be formed directly without a separate capture.
        S    <= res_nxt;
        COUT <= carry_nxt;
        OVF  <= c ^ carry_nxt;
        ZERO <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_sub
//   Directed bench for serial_adder_sub (WIDTH=8). The driver pushes expected
//   results into a queue as operations are issued; an independent monitor pops
//   and compares whenever DONE is seen, also checking latency and BUSY length.
// -----------------------------------------------------------------------------
module tb_serial_adder_sub;

  localparam int W = 8;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic         OP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CIN;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] S;
  logic         COUT;
  logic         OVF;
  logic         ZERO;

  serial_adder_sub #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .START(START),
    .OP   (OP),
    .A    (A),
    .B    (B),
    .CIN  (CIN),
    .BUSY (BUSY),
    .DONE (DONE),
    .S    (S),
    .COUT (COUT),
    .OVF  (OVF),
    .ZERO (ZERO)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int busy_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expectation per DONE pulse
  always @(negedge CLK) begin
    if (DONE) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got DONE=1, expected no DONE (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("s",        int'(S),    int'(e.s));
        chk("cout",     int'(COUT), int'(e.cout));
        chk("ovf",      int'(OVF),  int'(e.ovf));
        chk("zero",     int'(ZERO), int'(e.zero));
        chk("latency",  cyc,        e.cyc);
        chk("busy_len", busy_cnt,   W);
      end
      busy_cnt = 0;
    end else if (BUSY) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  // Issue one operation at the next edge; expectation is queued here
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [W-1:0] es, input logic ec,
                       input logic eo, input logic ez);
    exp_t e;
    OP = op; A = a; B = b; CIN = ci; START = 1'b1;
    e.s = es; e.cout = ec; e.ovf = eo; e.zero = ez;
    e.cyc = cyc + 1 + W;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no DONE, expected DONE within 40 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci, input logic [W-1:0] es,
                        input logic ec, input logic eo, input logic ez);
    @(negedge CLK);
    issue(op, a, b, ci, es, ec, eo, ez);
    @(negedge CLK);
    START = 1'b0;
    wait_done(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0; START = 1'b0; OP = 1'b0; A = '0; B = '0; CIN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_s",    int'(S),    0);
    chk("rst_cout", int'(COUT), 0);
    chk("rst_ovf",  int'(OVF),  0);
    chk("rst_zero", int'(ZERO), 1);

    // Add: signed overflow, carry wrap, carry-in only
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("add_cin",   1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

    // Subtract: borrow, and signed overflow without borrow
    run_op("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Back-to-back: START held high through the DONE cycle
    @(negedge CLK);
    issue(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    A = 8'h10; B = 8'h20; OP = 1'b0; CIN = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge CLK);
        if (DONE) seen = 1'b1;
      end
      if (!seen) begin
        tests++;
        fails++;
        $display("FAIL b2b_first_timeout: got no DONE, expected DONE within 40 cycles");
      end
    end
    // START is still high here, so the next edge begins the 0x10+0x20 op
    begin
      exp_t e;
      e.s = 8'h30; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0;
      e.cyc = cyc + 1 + W;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    START = 1'b0;
    wait_done("b2b_second");

    // Mid-run START pulses and operand changes must be ignored
    @(negedge CLK);
    issue(1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("hold_s_run", int'(S), 8'h30);
    START = 1'b1; OP = 1'b0; A = 8'hAA; B = 8'h55; CIN = 1'b1;
    @(negedge CLK);
    START = 1'b0; A = 8'h00;
    @(negedge CLK);
    START = 1'b1; B = 8'hFF;
    @(negedge CLK);
    START = 1'b0;
    wait_done("midrun");

    // Reset during RUN aborts with no DONE
    @(negedge CLK);
    OP = 1'b0; A = 8'h7F; B = 8'h01; CIN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_s",    int'(S),    0);
    chk("abort_zero", int'(ZERO), 1);
    RST_N = 1'b1;
    repeat (W + 2) @(negedge CLK);
    run_op("after_abort", 1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge CLK);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
